// File: rtl/piano_pkg.sv
// Shared definitions for the piano key front end and the tone generator.
package piano_pkg;

    localparam int NUM_KEYS = 4;
    localparam int NOTE_W   = 2;

    typedef logic [NOTE_W-1:0] note_idx_t;

    // Fixed priority: the highest-numbered pressed key wins.
    function automatic note_idx_t prio_encode(input logic [NUM_KEYS-1:0] k);
        note_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (k[i]) begin
                idx = note_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, disagreement counter and debounced level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic key_db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;

    // Bring the asynchronous key level into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after an unbroken run of disagreeing cycles; any agreement restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            key_db <= 1'b0;
        end else if (sync2 == key_db) begin
            count <= '0;
        end else if (count == LAST) begin
            key_db <= sync2;
            count  <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/key_debounce_encoder.sv
// Debounces the piano keys and reports the highest-priority pressed note.
module key_debounce_encoder
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 25000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys,
    output logic                note_valid,
    output note_idx_t           note_idx,
    output logic                note_change,
    output logic [NUM_KEYS-1:0] keys_db
);

    logic      valid_next;
    note_idx_t idx_next;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .key    (keys[i]),
            .key_db (keys_db[i])
        );
    end

    // Encode the debounced levels; the index is forced to 0 when nothing is pressed.
    always_comb begin
        valid_next = |keys_db;
        idx_next   = prio_encode(keys_db);
    end

    // Register the note and strobe note_change only when the registered pair actually moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_valid  <= 1'b0;
            note_idx    <= '0;
            note_change <= 1'b0;
        end else begin
            note_valid  <= valid_next;
            note_idx    <= idx_next;
            note_change <= ({valid_next, idx_next} != {note_valid, note_idx});
        end
    end

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Self-checking bench for key_debounce_encoder with DEBOUNCE_CYCLES = 4.
module tb_key_debounce_encoder;

    localparam int DC      = 4;
    localparam int LATENCY = 2 + DC + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] keys = 4'b0000;
    logic       note_valid;
    logic [1:0] note_idx;
    logic       note_change;
    logic [3:0] keys_db;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [3:0] keys;
        int         cycles;
        logic [3:0] expDb;
        logic       expValid;
        logic [1:0] expIdx;
        int         expPulses;
        int         expPulseEdge;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int pulseCount;
    int firstPulseEdge;

    key_debounce_encoder #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keys        (keys),
        .note_valid  (note_valid),
        .note_idx    (note_idx),
        .note_change (note_change),
        .keys_db     (keys_db)
    );

    always #5 clk = ~clk;

    task automatic checkOne(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one record at the falling edge, queue its expectation, and watch the strobe for its hold time.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        keys = v.keys;
        sb.push_back(v);
        pulseCount = 0;
        firstPulseEdge = 0;
        for (int e = 1; e <= v.cycles; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (note_change === 1'b1) begin
                pulseCount++;
                if (firstPulseEdge == 0) firstPulseEdge = e;
            end
        end
    endtask

    task automatic checkOutput(input int n);
        vec_t exp;
        exp = sb.pop_front();
        checkOne($sformatf("vec%0d keys_db", n), 32'(keys_db), 32'(exp.expDb));
        checkOne($sformatf("vec%0d note_valid", n), 32'(note_valid), 32'(exp.expValid));
        checkOne($sformatf("vec%0d note_idx", n), 32'(note_idx), 32'(exp.expIdx));
        checkOne($sformatf("vec%0d pulses", n), 32'(pulseCount), 32'(exp.expPulses));
        if (exp.expPulses > 0)
            checkOne($sformatf("vec%0d pulse_edge", n), 32'(firstPulseEdge), 32'(exp.expPulseEdge));
    endtask

    task automatic checkAllZero(input string name);
        checkOne({name, " outputs"}, 32'({keys_db, note_valid, note_idx, note_change}), 32'd0);
    endtask

    initial begin
        int edges;
        bit seen;

        vecs.push_back('{4'b1000, 10, 4'b1000, 1'b1, 2'd3, 1, LATENCY});
        vecs.push_back('{4'b0000, 10, 4'b0000, 1'b0, 2'd0, 1, LATENCY});
        vecs.push_back('{4'b0101, 10, 4'b0101, 1'b1, 2'd2, 1, LATENCY});
        vecs.push_back('{4'b0100, 10, 4'b0100, 1'b1, 2'd2, 0, 0});
        vecs.push_back('{4'b0101, 10, 4'b0101, 1'b1, 2'd2, 0, 0});
        vecs.push_back('{4'b0111, 10, 4'b0111, 1'b1, 2'd2, 0, 0});
        vecs.push_back('{4'b1111, 10, 4'b1111, 1'b1, 2'd3, 1, LATENCY});
        vecs.push_back('{4'b0000, 10, 4'b0000, 1'b0, 2'd0, 1, LATENCY});
        vecs.push_back('{4'b0001, 10, 4'b0001, 1'b1, 2'd0, 1, LATENCY});
        vecs.push_back('{4'b0011, 10, 4'b0011, 1'b1, 2'd1, 1, LATENCY});
        vecs.push_back('{4'b0010, 10, 4'b0010, 1'b1, 2'd1, 0, 0});
        vecs.push_back('{4'b0000, 10, 4'b0000, 1'b0, 2'd0, 1, LATENCY});

        // Reset with all keys pressed: outputs stay clear, also on the first edge after release.
        keys = 4'b1111;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("after_release");
        keys = 4'b0000;
        pulseCount = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (note_change === 1'b1) pulseCount++;
        end
        checkAllZero("short_after_reset");
        checkOne("release_pulses", 32'(pulseCount), 32'd0);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // Glitch: keys[1] high for DC-1 edges only must never be accepted.
        @(negedge clk);
        keys = 4'b0010;
        repeat (DC - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        keys = 4'b0000;
        pulseCount = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (note_change === 1'b1 || keys_db !== 4'b0000 || note_valid !== 1'b0) pulseCount++;
        end
        checkOne("glitch_disturbances", 32'(pulseCount), 32'd0);

        // Reset in the middle of a count discards it; latency restarts from release.
        @(negedge clk);
        keys = 4'b0010;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkAllZero("midcount_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        seen = 1'b0;
        pulseCount = 0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (note_valid === 1'b1 && note_idx === 2'd1) seen = 1'b1;
            if (note_change === 1'b1) pulseCount++;
        end
        checkOne("midcount_latency", 32'(edges), 32'(LATENCY));
        checkOne("midcount_pulse", 32'(pulseCount), 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOne("midcount_strobe_drops", 32'(note_change), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
